// File: rtl/ps2_pkg.sv
// Shared constants and types for the PS/2 key sequencer: protocol bytes,
// parser states and the key-event record.
package ps2_pkg;

    localparam logic [7:0] ByteE0 = 8'hE0;
    localparam logic [7:0] ByteF0 = 8'hF0;
    localparam logic [7:0] ByteFa = 8'hFA;
    localparam logic [7:0] ByteAa = 8'hAA;
    localparam logic [7:0] ByteEe = 8'hEE;
    localparam logic [7:0] Byte00 = 8'h00;
    localparam logic [7:0] ByteFf = 8'hFF;

    typedef enum logic [1:0] {
        StIdle,
        StGotE0,
        StGotF0,
        StGotE0F0
    } parse_state_e;

    typedef struct packed {
        logic       ext;
        logic       brk;
        logic [7:0] code;
    } key_event_t;

    function automatic logic is_prefix(input logic [7:0] b);
        return (b == ByteE0) || (b == ByteF0);
    endfunction

    // ACK, self-test pass and echo replies carry no key information.
    function automatic logic is_reply(input logic [7:0] b);
        return (b == ByteFa) || (b == ByteAa) || (b == ByteEe);
    endfunction

    function automatic logic is_overrun(input logic [7:0] b);
        return (b == Byte00) || (b == ByteFf);
    endfunction

endpackage

// File: rtl/ps2_event_fifo.sv
// Show-ahead synchronous FIFO for key events; a pop in the same cycle frees
// room for a push into a full buffer.
module ps2_event_fifo
    import ps2_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    input  logic                          push_i,
    input  key_event_t                    push_data_i,
    input  logic                          pop_i,
    output key_event_t                    head_o,
    output logic [$clog2(FIFO_DEPTH):0]   count_o,
    output logic                          empty_o,
    output logic                          push_dropped_o
);

    localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
    localparam int unsigned CntW = PtrW + 1;

    key_event_t      mem_q [FIFO_DEPTH];
    key_event_t      mem_d [FIFO_DEPTH];
    logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0] count_q, count_d;
    logic            empty, full, do_push, do_pop;

    assign empty   = (count_q == '0);
    assign full    = (count_q == CntW'(FIFO_DEPTH));
    assign do_pop  = pop_i && !empty;
    assign do_push = push_i && (!full || do_pop);

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = push_data_i;
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        if (do_push && !do_pop) begin
            count_d = count_q + 1'b1;
        end else if (do_pop && !do_push) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        mem_q <= mem_d;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage is not reset, so the head reads as zero whenever nothing is buffered.
    assign head_o         = empty ? '0 : mem_q[rd_ptr_q];
    assign count_o        = count_q;
    assign empty_o        = empty;
    assign push_dropped_o = push_i && !do_push;

endmodule

// File: rtl/ps2_key_sequencer.sv
// Turns the raw PS/2 scan-byte stream into make/break key events with
// prefix parsing, inter-byte timeout, typematic repeat filtering and buffering.
module ps2_key_sequencer
    import ps2_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 2_000_000,
    parameter int unsigned FIFO_DEPTH     = 4
) (
    input  logic       CLK,
    input  logic       reset,
    input  logic       rx_done_tick,
    input  logic [7:0] rx_data,
    input  logic       repeat_filter_en,
    output logic       rx_en,
    output logic       ev_valid,
    input  logic       ev_ready,
    output logic [7:0] ev_code,
    output logic       ev_ext,
    output logic       ev_break,
    output logic       seq_error
);

    localparam int unsigned TmoW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam int unsigned CntW = $clog2(FIFO_DEPTH) + 1;

    parse_state_e    state_q, state_d;
    logic [TmoW-1:0] tmo_cnt_q, tmo_cnt_d;
    logic            held_valid_q, held_valid_d;
    logic            held_ext_q, held_ext_d;
    logic [7:0]      held_code_q, held_code_d;
    logic            seq_error_q, seq_error_d;

    logic            timeout, parse_err, cand_valid, held_match, emit, pop, push_dropped;
    logic            fifo_empty;
    logic [CntW-1:0] count;
    key_event_t      cand, head;

    // Inter-byte timer only runs while a prefix is pending; any byte restarts it.
    always_comb begin
        timeout   = 1'b0;
        tmo_cnt_d = tmo_cnt_q + 1'b1;
        if (rx_done_tick || state_q == StIdle) begin
            tmo_cnt_d = '0;
        end else if (tmo_cnt_q == TmoW'(TIMEOUT_CYCLES - 1)) begin
            timeout   = 1'b1;
            tmo_cnt_d = '0;
        end
    end

    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (rx_done_tick) begin
            unique case (state_q)
                StIdle: begin
                    if (rx_data == ByteE0) begin
                        state_d = StGotE0;
                    end else if (rx_data == ByteF0) begin
                        state_d = StGotF0;
                    end
                end
                StGotE0: begin
                    if (rx_data == ByteF0) begin
                        state_d = StGotE0F0;
                    end else if (rx_data != ByteE0) begin
                        state_d = StIdle;
                    end
                end
                default: state_d = StIdle;
            endcase
        end else if (timeout) begin
            state_d = StIdle;
        end
    end

    always_comb begin
        cand_valid = 1'b0;
        parse_err  = 1'b0;
        cand       = '{ext: 1'b0, brk: 1'b0, code: rx_data};
        if (rx_done_tick) begin
            unique case (state_q)
                StIdle: begin
                    if (is_overrun(rx_data)) begin
                        parse_err = 1'b1;
                    end else if (!is_prefix(rx_data) && !is_reply(rx_data)) begin
                        cand_valid = 1'b1;
                    end
                end
                StGotE0: begin
                    if (rx_data == ByteE0) begin
                        parse_err = 1'b1;
                    end else if (rx_data != ByteF0) begin
                        cand_valid = 1'b1;
                        cand.ext   = 1'b1;
                    end
                end
                default: begin
                    if (is_prefix(rx_data)) begin
                        parse_err = 1'b1;
                    end else begin
                        cand_valid = 1'b1;
                        cand.brk   = 1'b1;
                        cand.ext   = (state_q == StGotE0F0);
                    end
                end
            endcase
        end
    end

    // Held key tracks the last make; a matching break releases it.
    always_comb begin
        held_valid_d = held_valid_q;
        held_ext_d   = held_ext_q;
        held_code_d  = held_code_q;
        emit         = 1'b0;
        held_match   = held_valid_q && (held_ext_q == cand.ext) && (held_code_q == cand.code);
        if (cand_valid) begin
            if (cand.brk) begin
                emit = 1'b1;
                if (held_match) begin
                    held_valid_d = 1'b0;
                end
            end else if (!(repeat_filter_en && held_match)) begin
                emit         = 1'b1;
                held_valid_d = 1'b1;
                held_ext_d   = cand.ext;
                held_code_d  = cand.code;
            end
        end
    end

    assign seq_error_d = parse_err || timeout || push_dropped;

    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            tmo_cnt_q    <= '0;
            held_valid_q <= 1'b0;
            held_ext_q   <= 1'b0;
            held_code_q  <= '0;
            seq_error_q  <= 1'b0;
        end else begin
            tmo_cnt_q    <= tmo_cnt_d;
            held_valid_q <= held_valid_d;
            held_ext_q   <= held_ext_d;
            held_code_q  <= held_code_d;
            seq_error_q  <= seq_error_d;
        end
    end

    assign pop = ev_valid && ev_ready;

    ps2_event_fifo #(
        .FIFO_DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk_i          (CLK),
        .rst_ni         (reset),
        .push_i         (emit),
        .push_data_i    (cand),
        .pop_i          (pop),
        .head_o         (head),
        .count_o        (count),
        .empty_o        (fifo_empty),
        .push_dropped_o (push_dropped)
    );

    // Keep one slot free for a byte the receiver may already be shifting in.
    assign rx_en     = (count <= CntW'(FIFO_DEPTH - 2));
    assign ev_valid  = !fifo_empty;
    assign ev_code   = head.code;
    assign ev_ext    = head.ext;
    assign ev_break  = head.brk;
    assign seq_error = seq_error_q;

endmodule
